counter_pulse_ctrl: RTL



---
 rtl/counter_pulse_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/counter_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// counter_pulse_ctrl
//
// Drives a bank of external negative-edge-triggered counter ICs. It generates
// one active-low clock per channel and a shared active-high counter reset, each
// with programmable pulse and gap widths. A controlling FSM makes a request
// with a one-cycle strobe and receives a BUSY/DONE handshake. The FSM does not
// have to hold the request for the IC's minimum pulse width.
//
// Optional feature, enabled by defining COUNTER_PULSE_ABORT_EN:
//   ABORT stops a burst at the end of the pulse in progress. The pulse is never
//   truncated. The gap that follows the pulse is still issued before IDLE.
//   ABORTED reports that the last burst ended early.
//
// Parameters:
//   NUM_CH   number of counter clock outputs
//   CNT_W    width of the burst pulse count
//   PULSE_W  CLK cycles a counter clock is low, or the counter reset is high (>=1)
//   GAP_W    CLK cycles a counter clock is high between pulses and after reset (>=1)
//
// Ports:
//   CLK            system clock
//   RST            asynchronous, active-high reset
//   ADVANCE_REQ    1-cycle request to issue ADVANCE_COUNT clock pulses
//   RESET_REQ      1-cycle request to issue one counter reset pulse;
//                  it has priority over ADVANCE_REQ
//   ADVANCE_COUNT  number of pulses, sampled with ADVANCE_REQ
//   CH_MASK        1 = the channel takes part; sampled with the request
//   ABORT          (optional) finish the current pulse and its gap, then stop
//   COUNTER_CLK    counter IC clocks; idle high, active-low pulses
//   COUNTER_RST    counter IC reset; active-high pulse
//   BUSY           high while a request is executing
//   DONE           1-cycle strobe when a request completes
//   PULSE_CNT      pulses issued in the current or last burst
//   ABORTED        (optional) the last burst was cut short by ABORT
// -----------------------------------------------------------------------------
module counter_pulse_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 8,
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ADVANCE_REQ,
   input  logic              RESET_REQ,
   input  logic [CNT_W-1:0]  ADVANCE_COUNT,
   input  logic [NUM_CH-1:0] CH_MASK,
`ifdef COUNTER_PULSE_ABORT_EN
   input  logic              ABORT,
   output logic              ABORTED,
`endif
   output logic [NUM_CH-1:0] COUNTER_CLK,
   output logic              COUNTER_RST,
   output logic              BUSY,
   output logic              DONE,
   output logic [CNT_W-1:0]  PULSE_CNT
);

   localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int TMR_W = $clog2(MAX_W + 1);

   // Terminal values of the phase timer. The timer counts 0 .. N-1, so each
   // phase lasts exactly N cycles.
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      RST_HI,
      RST_GAP,
      CLK_LO,
      CLK_HI
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  timer;
   logic [CNT_W-1:0]  burst_len;   // pulse count latched at the request
   logic [NUM_CH-1:0] burst_mask;  // channel mask latched at the request
   logic              abort_seen;  // an abort is pending or arriving now

`ifdef COUNTER_PULSE_ABORT_EN
   logic abort_pending;
   // An ABORT on the last cycle of the gap must still count, so the live input
   // is combined with the stored flag.
   assign abort_seen = abort_pending | ABORT;
`else
   assign abort_seen = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         timer       <= '0;
         burst_len   <= '0;
         burst_mask  <= '0;
         COUNTER_CLK <= '1;
         COUNTER_RST <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         PULSE_CNT   <= '0;
`ifdef COUNTER_PULSE_ABORT_EN
         abort_pending <= 1'b0;
         ABORTED       <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout. The default written here
         // is overridden by any later assignment in this block on the same
         // edge, which is what turns DONE into a single-cycle strobe.
         DONE <= 1'b0;

         case (state)
            IDLE: begin
               timer <= '0;
               if (RESET_REQ) begin
                  state       <= RST_HI;
                  COUNTER_RST <= 1'b1;
                  BUSY        <= 1'b1;
`ifdef COUNTER_PULSE_ABORT_EN
                  ABORTED <= 1'b0;
`endif
               end else if (ADVANCE_REQ) begin
                  PULSE_CNT <= '0;
`ifdef COUNTER_PULSE_ABORT_EN
                  ABORTED       <= 1'b0;
                  abort_pending <= 1'b0;
`endif
                  if (ADVANCE_COUNT == '0) begin
                     // An empty burst completes immediately and never raises BUSY.
                     DONE <= 1'b1;
                  end else begin
                     burst_len   <= ADVANCE_COUNT;
                     burst_mask  <= CH_MASK;
                     COUNTER_CLK <= ~CH_MASK;
                     BUSY        <= 1'b1;
                     state       <= CLK_LO;
                  end
               end
            end

            RST_HI: begin
               if (timer == PULSE_LAST) begin
                  timer       <= '0;
                  COUNTER_RST <= 1'b0;
                  state       <= RST_GAP;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            RST_GAP: begin
               if (timer == GAP_LAST) begin
                  timer <= '0;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            CLK_LO: begin
`ifdef COUNTER_PULSE_ABORT_EN
               if (ABORT) abort_pending <= 1'b1;
`endif
               if (timer == PULSE_LAST) begin
                  // Rising edge on the masked-in channels. PULSE_CNT cannot
                  // pass burst_len, so it never wraps.
                  timer       <= '0;
                  COUNTER_CLK <= '1;
                  PULSE_CNT   <= PULSE_CNT + CNT_W'(1);
                  state       <= CLK_HI;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            CLK_HI: begin
`ifdef COUNTER_PULSE_ABORT_EN
               if (ABORT) abort_pending <= 1'b1;
`endif
               if (timer == GAP_LAST) begin
                  timer <= '0;
                  if (PULSE_CNT == burst_len || abort_seen) begin
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     state <= IDLE;
`ifdef COUNTER_PULSE_ABORT_EN
                     ABORTED       <= abort_seen;
                     abort_pending <= 1'b0;
`endif
                  end else begin
                     COUNTER_CLK <= ~burst_mask;
                     state       <= CLK_LO;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
